// File: rtl/label_scan_ctrl.sv
// label_scan_ctrl: raster-scan sequencer for the connected-component labeler.
// Tracks col/row, keeps a one-row line buffer of previous-row labels and a
// left-neighbour register, and clears the line buffer between frames.
// Optional build macro LABEL_SCAN_STATS_EN adds per-frame motion / new-label
// counters on stat_motion_cnt and stat_new_cnt.
module label_scan_ctrl #(
   parameter int unsigned LABEL_WIDTH = 8,
   parameter int unsigned IMG_W       = 320,
   parameter int unsigned IMG_H       = 240
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic                       pix_valid,
   input  logic                       pix_motion,
   output logic                       pix_ready,
   input  logic                       merger_busy,
   output logic                       lab_enable,
   output logic                       lab_motion,
   output logic [LABEL_WIDTH-1:0]     lab_left,
   output logic [LABEL_WIDTH-1:0]     lab_top,
   output logic                       lab_last,
   input  logic [LABEL_WIDTH-1:0]     lab_current,
   input  logic                       lab_new_valid,
   input  logic [LABEL_WIDTH-1:0]     lab_new_value,
   output logic [$clog2(IMG_W)-1:0]   col,
   output logic [$clog2(IMG_H)-1:0]   row,
   output logic                       frame_done,
   output logic                       label_overflow
`ifdef LABEL_SCAN_STATS_EN
   ,
   output logic [$clog2(IMG_W*IMG_H+1)-1:0] stat_motion_cnt,
   output logic [$clog2(IMG_W*IMG_H+1)-1:0] stat_new_cnt
`endif
);

   localparam int unsigned COL_W = $clog2(IMG_W);
   localparam int unsigned ROW_W = $clog2(IMG_H);

   typedef enum logic [0:0] {
      ST_CLEAR = 1'b0,
      ST_SCAN  = 1'b1
   } state_e;

   state_e                 state_q, state_d;
   logic [COL_W-1:0]       clr_idx_q, clr_idx_d;
   logic [COL_W-1:0]       col_q, col_d;
   logic [ROW_W-1:0]       row_q, row_d;
   logic [LABEL_WIDTH-1:0] left_q, left_d;
   logic                   frame_done_q, frame_done_d;
   logic                   ovf_q, ovf_d;

   logic [LABEL_WIDTH-1:0] linebuf_q [IMG_W];
   logic                   lb_we_d;
   logic [COL_W-1:0]       lb_addr_d;
   logic [LABEL_WIDTH-1:0] lb_wdata_d;

   logic                   accept_c;
   logic                   last_c;

   // Control state, position counters, left register and status flags.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q      <= ST_CLEAR;
         clr_idx_q    <= '0;
         col_q        <= '0;
         row_q        <= '0;
         left_q       <= '0;
         frame_done_q <= 1'b0;
         ovf_q        <= 1'b0;
      end else begin
         state_q      <= state_d;
         clr_idx_q    <= clr_idx_d;
         col_q        <= col_d;
         row_q        <= row_d;
         left_q       <= left_d;
         frame_done_q <= frame_done_d;
         ovf_q        <= ovf_d;
      end
   end

   // Line buffer storage; contents are initialised by the CLEAR sweep.
   always_ff @(posedge clk) begin
      if (lb_we_d) begin
         linebuf_q[lb_addr_d] <= lb_wdata_d;
      end
   end

   // Next-state, buffer write and zero-latency labeler drive.
   always_comb begin
      state_d      = state_q;
      clr_idx_d    = clr_idx_q;
      col_d        = col_q;
      row_d        = row_q;
      left_d       = left_q;
      frame_done_d = 1'b0;
      ovf_d        = ovf_q;
      lb_we_d      = 1'b0;
      lb_addr_d    = col_q;
      lb_wdata_d   = '0;
      pix_ready    = 1'b0;
      accept_c     = 1'b0;
      last_c       = 1'b0;
      lab_enable   = 1'b0;
      lab_motion   = 1'b0;
      lab_left     = '0;
      lab_top      = '0;
      lab_last     = 1'b0;

      case (state_q)
         ST_CLEAR: begin
            lb_we_d   = 1'b1;
            lb_addr_d = clr_idx_q;
            if (clr_idx_q == COL_W'(IMG_W - 1)) begin
               clr_idx_d    = '0;
               state_d      = ST_SCAN;
               frame_done_d = 1'b1;
               ovf_d        = 1'b0;
            end else begin
               clr_idx_d = clr_idx_q + COL_W'(1);
            end
         end

         ST_SCAN: begin
            pix_ready = !merger_busy;
            accept_c  = pix_valid && !merger_busy;
            last_c    = accept_c && (col_q == COL_W'(IMG_W - 1)) &&
                        (row_q == ROW_W'(IMG_H - 1));
            if (accept_c) begin
               lab_enable = 1'b1;
               lab_motion = pix_motion;
               lab_left   = (col_q == '0) ? '0 : left_q;
               lab_top    = linebuf_q[col_q];
               lab_last   = last_c;
               // Non-motion pixels store background label 0.
               lb_we_d    = 1'b1;
               lb_wdata_d = pix_motion ? lab_current : '0;
               left_d     = lb_wdata_d;
               if (lab_new_valid && (lab_new_value == '0)) begin
                  ovf_d = 1'b1;
               end
               if (col_q == COL_W'(IMG_W - 1)) begin
                  col_d = '0;
                  if (row_q == ROW_W'(IMG_H - 1)) begin
                     row_d     = '0;
                     clr_idx_d = '0;
                     state_d   = ST_CLEAR;
                  end else begin
                     row_d = row_q + ROW_W'(1);
                  end
               end else begin
                  col_d = col_q + COL_W'(1);
               end
            end
         end

         default: state_d = ST_CLEAR;
      endcase
   end

   assign col            = col_q;
   assign row            = row_q;
   assign frame_done     = frame_done_q;
   assign label_overflow = ovf_q;

`ifdef LABEL_SCAN_STATS_EN
   localparam int unsigned STAT_W = $clog2(IMG_W * IMG_H + 1);

   logic [STAT_W-1:0] motion_cnt_q, motion_cnt_d;
   logic [STAT_W-1:0] new_cnt_q, new_cnt_d;
   logic [STAT_W-1:0] stat_motion_q, stat_motion_d;
   logic [STAT_W-1:0] stat_new_q, stat_new_d;
   logic [STAT_W-1:0] motion_inc_c, new_inc_c;

   // Per-frame statistics registers.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         motion_cnt_q  <= '0;
         new_cnt_q     <= '0;
         stat_motion_q <= '0;
         stat_new_q    <= '0;
      end else begin
         motion_cnt_q  <= motion_cnt_d;
         new_cnt_q     <= new_cnt_d;
         stat_motion_q <= stat_motion_d;
         stat_new_q    <= stat_new_d;
      end
   end

   // Count accepts; the final pixel's own contribution is included in the latch.
   always_comb begin
      motion_cnt_d  = motion_cnt_q;
      new_cnt_d     = new_cnt_q;
      stat_motion_d = stat_motion_q;
      stat_new_d    = stat_new_q;
      motion_inc_c  = motion_cnt_q + STAT_W'(pix_motion);
      new_inc_c     = new_cnt_q + STAT_W'(lab_new_valid);
      if (accept_c) begin
         if (last_c) begin
            stat_motion_d = motion_inc_c;
            stat_new_d    = new_inc_c;
            motion_cnt_d  = '0;
            new_cnt_d     = '0;
         end else begin
            motion_cnt_d = motion_inc_c;
            new_cnt_d    = new_inc_c;
         end
      end
   end

   assign stat_motion_cnt = stat_motion_q;
   assign stat_new_cnt    = stat_new_q;
`endif

endmodule

// File: tb/tb_label_scan_ctrl.sv
// Directed bench for label_scan_ctrl with a 4x3 image.
module tb_label_scan_ctrl;

   localparam int unsigned LW = 8;
   localparam int unsigned W  = 4;
   localparam int unsigned H  = 3;

   logic          clk = 1'b0;
   logic          rst;
   logic          pix_valid, pix_motion, pix_ready, merger_busy;
   logic          lab_enable, lab_motion, lab_last;
   logic [LW-1:0] lab_left, lab_top, lab_current, lab_new_value;
   logic          lab_new_valid;
   logic [1:0]    col;
   logic [1:0]    row;
   logic          frame_done, label_overflow;
`ifdef LABEL_SCAN_STATS_EN
   logic [3:0]    stat_motion_cnt, stat_new_cnt;
`endif

   int n_vec = 0;
   int n_err = 0;
   int n;

   logic          cap_en, cap_motion, cap_last;
   logic [LW-1:0] cap_left, cap_top;
   logic [1:0]    cap_col, cap_row;

   // Frame 2 vectors, index = row*4 + col.
   logic          f2_m    [12] = '{0,1,0,1, 0,1,0,0, 1,0,1,0};
   logic [LW-1:0] f2_cur  [12] = '{8'h55,8'd1,8'h55,8'd2, 8'h55,8'd1,8'h55,8'h55, 8'd3,8'h55,8'd3,8'h55};
   logic          f2_nv   [12] = '{0,1,0,1, 0,0,0,0, 0,0,0,0};
   logic [LW-1:0] f2_nval [12] = '{8'd0,8'd1,8'd0,8'd2, 8'd0,8'd0,8'd0,8'd0, 8'd0,8'd0,8'd0,8'd0};
   logic [LW-1:0] f2_left [12] = '{8'd0,8'd0,8'd1,8'd0, 8'd0,8'd0,8'd1,8'd0, 8'd0,8'd3,8'd0,8'd3};
   logic [LW-1:0] f2_top  [12] = '{8'd0,8'd0,8'd0,8'd0, 8'd0,8'd1,8'd0,8'd2, 8'd0,8'd1,8'd0,8'd0};

   label_scan_ctrl #(.LABEL_WIDTH(LW), .IMG_W(W), .IMG_H(H)) dut (
      .clk            (clk),
      .rst            (rst),
      .pix_valid      (pix_valid),
      .pix_motion     (pix_motion),
      .pix_ready      (pix_ready),
      .merger_busy    (merger_busy),
      .lab_enable     (lab_enable),
      .lab_motion     (lab_motion),
      .lab_left       (lab_left),
      .lab_top        (lab_top),
      .lab_last       (lab_last),
      .lab_current    (lab_current),
      .lab_new_valid  (lab_new_valid),
      .lab_new_value  (lab_new_value),
      .col            (col),
      .row            (row),
      .frame_done     (frame_done),
      .label_overflow (label_overflow)
`ifdef LABEL_SCAN_STATS_EN
      ,
      .stat_motion_cnt(stat_motion_cnt),
      .stat_new_cnt   (stat_new_cnt)
`endif
   );

   // 10 ns clock.
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0d expected %0d", tag, got, exp);
      end
   endtask

   // Present one pixel at the negedge, capture the labeler drive, let it be accepted.
   task automatic accept_pix(input logic m, input logic [LW-1:0] cur,
                             input logic nv, input logic [LW-1:0] nval);
      @(negedge clk);
      pix_valid = 1'b1; pix_motion = m; merger_busy = 1'b0;
      lab_current = cur; lab_new_valid = nv; lab_new_value = nval;
      #1;
      chk("acc_ready", 32'(pix_ready), 32'd1);
      cap_en = lab_enable; cap_motion = lab_motion; cap_last = lab_last;
      cap_left = lab_left; cap_top = lab_top; cap_col = col; cap_row = row;
      @(posedge clk);
      #1;
      pix_valid = 1'b0; pix_motion = 1'b0; lab_current = '0;
      lab_new_valid = 1'b0; lab_new_value = '0;
   endtask

   // Count negedges until frame_done, bounded.
   task automatic wait_fd(input int start, output int cnt);
      cnt = start;
      do begin
         @(negedge clk);
         #1;
         cnt++;
      end while (!frame_done && cnt < 20);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      rst = 1'b1; pix_valid = 1'b1; pix_motion = 1'b0; merger_busy = 1'b0;
      lab_current = '0; lab_new_valid = 1'b0; lab_new_value = '0;
      repeat (2) @(negedge clk);
      #1;
      chk("rst_ready", 32'(pix_ready), 32'd0);
      chk("rst_en", 32'(lab_enable), 32'd0);
      chk("rst_col", 32'(col), 32'd0);
      chk("rst_row", 32'(row), 32'd0);
      chk("rst_fd", 32'(frame_done), 32'd0);
      chk("rst_ovf", 32'(label_overflow), 32'd0);
`ifdef LABEL_SCAN_STATS_EN
      chk("rst_stat_m", 32'(stat_motion_cnt), 32'd0);
      chk("rst_stat_n", 32'(stat_new_cnt), 32'd0);
`endif

      // Initial CLEAR: exactly 4 stalled cycles, then a single frame_done.
      @(negedge clk);
      rst = 1'b0;
      for (int i = 0; i < 4; i++) begin
         #1;
         chk("clr_ready", 32'(pix_ready), 32'd0);
         chk("clr_en", 32'(lab_enable), 32'd0);
         chk("clr_fd", 32'(frame_done), 32'd0);
         @(negedge clk);
      end
      #1;
      chk("scan_ready", 32'(pix_ready), 32'd1);
      chk("fd_pulse", 32'(frame_done), 32'd1);
      pix_valid = 1'b0;
      @(negedge clk);
      #1;
      chk("fd_once", 32'(frame_done), 32'd0);
      chk("scan_ready2", 32'(pix_ready), 32'd1);

      // Frame 1: all background, one exhausted-label event at pixel 5.
      for (int i = 0; i < 12; i++) begin
         accept_pix(1'b0, 8'd0, (i == 5), 8'd0);
         chk("f1_en", 32'(cap_en), 32'd1);
         chk("f1_col", 32'(cap_col), 32'(i % 4));
         chk("f1_row", 32'(cap_row), 32'(i / 4));
         chk("f1_last", 32'(cap_last), 32'(i == 11));
         chk("f1_ovf", 32'(label_overflow), 32'(i >= 5));
      end
      @(negedge clk);
      pix_valid = 1'b1;
      #1;
      chk("f1_end_ready", 32'(pix_ready), 32'd0);
      chk("f1_end_en", 32'(lab_enable), 32'd0);
      chk("f1_end_col", 32'(col), 32'd0);
      chk("f1_end_row", 32'(row), 32'd0);
      chk("f1_end_ovf", 32'(label_overflow), 32'd1);
      wait_fd(1, n);
      pix_valid = 1'b0;
      chk("f1_clear_len", 32'(n), 32'd5);
      chk("f1_ovf_clr", 32'(label_overflow), 32'd0);
`ifdef LABEL_SCAN_STATS_EN
      chk("f1_stat_m", 32'(stat_motion_cnt), 32'd0);
      chk("f1_stat_n", 32'(stat_new_cnt), 32'd1);
`endif

      // Frame 2: motion pixels with a scripted labeler; non-motion carries junk labels.
      for (int i = 0; i < 12; i++) begin
         accept_pix(f2_m[i], f2_cur[i], f2_nv[i], f2_nval[i]);
         chk("f2_motion", 32'(cap_motion), 32'(f2_m[i]));
         chk("f2_left", 32'(cap_left), 32'(f2_left[i]));
         chk("f2_top", 32'(cap_top), 32'(f2_top[i]));
      end
      wait_fd(0, n);
      chk("f2_clear_len", 32'(n), 32'd5);
      chk("f2_ovf", 32'(label_overflow), 32'd0);
`ifdef LABEL_SCAN_STATS_EN
      chk("f2_stat_m", 32'(stat_motion_cnt), 32'd5);
      chk("f2_stat_n", 32'(stat_new_cnt), 32'd2);
`endif

      // Frame 3: buffer cleared, then a 3-cycle merger stall mid-row.
      accept_pix(1'b1, 8'd4, 1'b0, 8'd0);
      chk("f3_top_cleared", 32'(cap_top), 32'd0);
      accept_pix(1'b1, 8'd4, 1'b0, 8'd0);
      chk("f3_left1", 32'(cap_left), 32'd4);
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         pix_valid = 1'b1; merger_busy = 1'b1;
         #1;
         chk("stall_ready", 32'(pix_ready), 32'd0);
         chk("stall_en", 32'(lab_enable), 32'd0);
         chk("stall_col", 32'(col), 32'd2);
      end
      @(negedge clk);
      merger_busy = 1'b0; pix_valid = 1'b0;
      #1;
      chk("idle_ready", 32'(pix_ready), 32'd1);
      chk("idle_en", 32'(lab_enable), 32'd0);
      chk("idle_col", 32'(col), 32'd2);
      accept_pix(1'b0, 8'h55, 1'b0, 8'd0);
      chk("resume_col", 32'(cap_col), 32'd2);
      chk("resume_left", 32'(cap_left), 32'd4);
      chk("resume_col_next", 32'(col), 32'd3);

      // Mid-frame reset discards the partial frame.
      @(negedge clk);
      rst = 1'b1;
      #1;
      chk("mrst_col", 32'(col), 32'd0);
      chk("mrst_ready", 32'(pix_ready), 32'd0);
      @(negedge clk);
      rst = 1'b0;
      wait_fd(0, n);
      chk("mrst_clear_len", 32'(n), 32'd4);
`ifdef LABEL_SCAN_STATS_EN
      chk("mrst_stat_m", 32'(stat_motion_cnt), 32'd0);
`endif
      accept_pix(1'b0, 8'd0, 1'b0, 8'd0);
      chk("mrst_first_col", 32'(cap_col), 32'd0);
      chk("mrst_first_row", 32'(cap_row), 32'd0);
      chk("mrst_first_top", 32'(cap_top), 32'd0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
